// File: rtl/nmi_rr_arbiter.sv
// Round-robin arbiter sharing one NMI slave port between NUM_MST masters, one transaction outstanding.
// Optional watchdog enabled by defining NMI_ARB_TIMEOUT_EN (forced completion with 32'hDEAD_BEEF, sticky err_o).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no transaction; arbitrate from ptr and latch winner's fields
// ST_BUSY | s_valid_o high; wait for s_ready_i (or watchdog expiry)
module nmi_rr_arbiter #(
   parameter int NUM_MST     = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_MST-1:0]        m_valid_i,
   input  logic [NUM_MST-1:0][31:0]  m_addr_i,
   input  logic [NUM_MST-1:0][31:0]  m_wdata_i,
   input  logic [NUM_MST-1:0][3:0]   m_wstrb_i,
   output logic [NUM_MST-1:0]        m_ready_o,
   output logic [31:0]               m_rdata_o,
   output logic                      s_valid_o,
   output logic [31:0]               s_addr_o,
   output logic [31:0]               s_wdata_o,
   output logic [3:0]                s_wstrb_o,
   input  logic                      s_ready_i,
   input  logic [31:0]               s_rdata_i,
   output logic [NUM_MST-1:0]        grant_o,
   output logic                      err_o
);

   localparam int IW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
   localparam int SW = IW + 1;

   if (NUM_MST < 2 || NUM_MST > 8 || TIMEOUT_CYC < 2) begin : g_param_check
      $error("nmi_rr_arbiter: unsupported NUM_MST or TIMEOUT_CYC");
   end

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q;
   logic [IW-1:0] gidx_q;
   logic [IW-1:0] pick_idx;
   logic [SW-1:0] pick_pos;
   logic          pick_found;
   logic          tmo;
   logic          done;

   // First requester at or after ptr, wrapping modulo NUM_MST.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_pos   = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         pick_pos = {1'b0, ptr_q} + SW'(i);
         if (pick_pos >= SW'(NUM_MST)) pick_pos = pick_pos - SW'(NUM_MST);
         if (!pick_found && m_valid_i[pick_pos[IW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = pick_pos[IW-1:0];
         end
      end
   end

   assign done = (state_q == ST_BUSY) && (s_ready_i || tmo);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (pick_found) state_d = ST_BUSY;
         ST_BUSY: if (done)       state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      s_valid_o = (state_q == ST_BUSY);
      m_ready_o = '0;
      if (done) m_ready_o[gidx_q] = 1'b1;
      m_rdata_o = s_rdata_i;
      if (tmo && !s_ready_i) m_rdata_o = 32'hDEAD_BEEF;
   end

   // Request fields and owner are frozen at grant; ptr only moves on completion.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s_addr_o  <= '0;
         s_wdata_o <= '0;
         s_wstrb_o <= '0;
         grant_o   <= '0;
         gidx_q    <= '0;
         ptr_q     <= '0;
      end else if (state_q == ST_IDLE && pick_found) begin
         s_addr_o  <= m_addr_i[pick_idx];
         s_wdata_o <= m_wdata_i[pick_idx];
         s_wstrb_o <= m_wstrb_i[pick_idx];
         grant_o   <= NUM_MST'(1) << pick_idx;
         gidx_q    <= pick_idx;
      end else if (done) begin
         grant_o <= '0;
         ptr_q   <= (gidx_q == IW'(NUM_MST - 1)) ? '0 : gidx_q + 1'b1;
      end
   end

`ifdef NMI_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC) + 1;

   logic [CW-1:0] tmo_cnt_q;
   logic          err_q;

   assign tmo   = (state_q == ST_BUSY) && (tmo_cnt_q == CW'(TIMEOUT_CYC - 1));
   assign err_o = err_q;

   // A slave answer in the expiry cycle wins: normal completion, no error.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         if (state_q == ST_IDLE) tmo_cnt_q <= '0;
         else                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
         if (tmo && !s_ready_i)  err_q     <= 1'b1;
      end
   end
`else
   assign tmo   = 1'b0;
   assign err_o = 1'b0;
`endif

endmodule
